// File: rtl/tpu_skew_feeder.sv
// Operand feeder for one edge of a DIM x DIM systolic MAC array: accepts one
// vector per handshake, re-emits it diagonally skewed, then drains zeros.
module tpu_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld_in,
    output logic                   rdy_out,
    input  logic [DIM*BITS_AB-1:0] vec_in,
    input  logic                   last_in,
    output logic [DIM*BITS_AB-1:0] a_skew,
    output logic                   en_out,
    output logic                   busy,
    output logic                   done
);
    localparam int DRAIN_N = 2*DIM - 2;
    localparam int CW      = $clog2(DIM + 1);
    localparam int DW      = $clog2(2*DIM);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DIM);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIM - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_N > 0) ? DRAIN_N - 1 : 0);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            en_q, done_q, done_d;
    logic            accept, shift;

    assign rdy_out = (state_q != DRAIN);
    assign busy    = (state_q != IDLE);
    assign accept  = vld_in & rdy_out;
    assign shift   = accept | (state_q == DRAIN);
    assign en_out  = en_q;
    assign done    = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, FEED: begin
                if (accept) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    // The DIM-th vector closes the tile even without last_in.
                    if (last_in || (cnt_q == CNT_LAST)) begin
                        drain_d = '0;
                        if (DRAIN_N == 0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    drain_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            en_q    <= shift;
            done_q  <= done_d;
        end
    end

    // Lane i is i+1 deep so its data lags lane 0 by i enabled cycles.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic [i:0][BITS_AB-1:0] pipe_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else if (shift) begin
                pipe_q[0] <= accept ? vec_in[i*BITS_AB +: BITS_AB] : '0;
                for (int s = 1; s <= i; s++) pipe_q[s] <= pipe_q[s-1];
            end
        end

        assign a_skew[i*BITS_AB +: BITS_AB] = pipe_q[i];
    end

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Directed bench for tpu_skew_feeder at DIM=4, BITS_AB=8; en-cycle data is
// compared against a diagonal-skew reference built from the stimulus vectors.
module tb_tpu_skew_feeder;
    localparam int DIM = 4;
    localparam int BITS_AB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld_in;
    logic        rdy_out;
    logic [31:0] vec_in;
    logic        last_in;
    logic [31:0] a_skew;
    logic        en_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_n = 0;
    int done_seen = 0;
    int rdy_lo = 0;
    logic [31:0] lane_log [64];
    logic        done_log [64];
    int          en_cyc   [64];
    logic [31:0] tv       [8];
    logic [31:0] hold;

    tpu_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_out(rdy_out),
        .vec_in(vec_in), .last_in(last_in), .a_skew(a_skew),
        .en_out(en_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (en_out === 1'b1) begin
            if (en_n < 64) begin
                lane_log[en_n] = a_skew;
                done_log[en_n] = done;
                en_cyc[en_n]   = cyc;
            end
            en_n++;
        end
        if (done === 1'b1) done_seen++;
        if (rdy_out === 1'b0) rdy_lo++;
    endtask

    task automatic clr_log();
        en_n = 0; done_seen = 0; rdy_lo = 0;
        for (int j = 0; j < 64; j++) begin
            lane_log[j] = 'x; done_log[j] = 1'b0; en_cyc[j] = 0;
        end
    endtask

    // Lane i at en-cycle c (1-based) carries element c-i-1 of the tile, else zero.
    function automatic logic [31:0] model(input int off, input int k_n, input int c);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            int k;
            k = c - i - 1;
            if (k >= 0 && k < k_n) r[i*8 +: 8] = tv[off + k][i*8 +: 8];
        end
        return r;
    endfunction

    task automatic check_tile(input string tag, input int base, input int off,
                              input int k_n, input int total);
        for (int c = 1; c <= total; c++)
            chk($sformatf("%s_en%0d", tag, c), lane_log[base + c - 1], model(off, k_n, c));
    endtask

    task automatic send(input logic [31:0] v, input logic l);
        vld_in = 1'b1; vec_in = v; last_in = l;
        step();
    endtask

    initial begin
        rst_n = 1'b0; vld_in = 1'b0; vec_in = '0; last_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_skew", a_skew, 32'h0);
        chk("rst_en", en_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", rdy_out, 1);
        #2 rst_n = 1'b1;

        // 1: continuous tile
        clr_log();
        tv[0] = 32'h03020100; tv[1] = 32'h13121110;
        tv[2] = 32'h23222120; tv[3] = 32'h33323130;
        for (int k = 0; k < 4; k++) send(tv[k], k == 3);
        vld_in = 1'b0; last_in = 1'b0;
        repeat (8) step();
        chk("t1_en_count", en_n, 10);
        chk("t1_en_contig", en_cyc[9] - en_cyc[0], 9);
        chk("t1_done_cnt", done_seen, 1);
        chk("t1_done_pos", done_log[9], 1);
        for (int c = 1; c <= 10; c++)
            chk($sformatf("t1_lane2_en%0d", c), lane_log[c-1][23:16],
                (c >= 3 && c <= 6) ? 32'(16*(c-3) + 2) : 32'h0);
        check_tile("t1", 0, 0, 4, 10);
        chk("t1_idle_busy", busy, 0);

        // 2: two-cycle stall between v1 and v2
        clr_log();
        send(tv[0], 1'b0);
        send(tv[1], 1'b0);
        vld_in = 1'b0;
        hold = a_skew;
        step();
        chk("t2_stall1_en", en_out, 0);
        chk("t2_stall1_hold", a_skew, hold);
        step();
        chk("t2_stall2_en", en_out, 0);
        chk("t2_stall2_hold", a_skew, hold);
        send(tv[2], 1'b0);
        send(tv[3], 1'b1);
        vld_in = 1'b0; last_in = 1'b0;
        repeat (8) step();
        chk("t2_en_count", en_n, 10);
        chk("t2_done_pos", done_log[9], 1);
        chk("t2_done_cnt", done_seen, 1);
        check_tile("t2", 0, 0, 4, 10);

        // 3: single vector with last from IDLE
        clr_log();
        tv[0] = 32'h04030201;
        send(tv[0], 1'b1);
        vld_in = 1'b0; last_in = 1'b0;
        repeat (8) step();
        chk("t3_en_count", en_n, 7);
        chk("t3_lane3_en4", lane_log[3][31:24], 32'h04);
        chk("t3_rdy_low_cycles", rdy_lo, 6);
        chk("t3_done_pos", done_log[6], 1);
        chk("t3_done_cnt", done_seen, 1);
        check_tile("t3", 0, 0, 1, 7);

        // 4: five vectors offered; the 4th forces drain, the 5th waits for done
        clr_log();
        tv[0] = 32'h44434241; tv[1] = 32'h54535251;
        tv[2] = 32'h64636261; tv[3] = 32'h74737271; tv[4] = 32'hF4F3F2F1;
        for (int k = 0; k < 4; k++) send(tv[k], 1'b0);
        chk("t4_rdy_forced", rdy_out, 0);
        chk("t4_busy", busy, 1);
        // v4 carries last so its own tile closes after one vector
        vld_in = 1'b1; vec_in = tv[4]; last_in = 1'b1;
        repeat (7) step();
        vld_in = 1'b0; last_in = 1'b0;
        repeat (8) step();
        chk("t4_en_count", en_n, 17);
        chk("t4_en_contig", en_cyc[16] - en_cyc[0], 16);
        chk("t4_done_a", done_log[9], 1);
        chk("t4_done_b", done_log[16], 1);
        chk("t4_done_cnt", done_seen, 2);
        check_tile("t4a", 0, 0, 4, 10);
        check_tile("t4b", 10, 4, 1, 7);

        // 5: reset pulse in the middle of drain
        clr_log();
        tv[0] = 32'h03020100; tv[1] = 32'h13121110;
        tv[2] = 32'h23222120; tv[3] = 32'h33323130;
        for (int k = 0; k < 4; k++) send(tv[k], k == 3);
        vld_in = 1'b0; last_in = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_a_skew", a_skew, 32'h0);
        chk("t5_rst_en", en_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        #1;
        chk("t5_rel_rdy", rdy_out, 1);
        chk("t5_rel_busy", busy, 0);
        repeat (6) step();
        chk("t5_no_done", done_seen, 0);
        chk("t5_idle_en", en_out, 0);
        chk("t5_idle_a_skew", a_skew, 32'h0);

        // 6: extreme signed values pass bit-exact
        clr_log();
        tv[0] = 32'h7F807F80; tv[1] = 32'h807F807F;
        send(tv[0], 1'b0);
        send(tv[1], 1'b1);
        vld_in = 1'b0; last_in = 1'b0;
        repeat (8) step();
        chk("t6_en_count", en_n, 8);
        chk("t6_lane0_en1", 32'($signed(lane_log[0][7:0])), 32'hFFFFFF80);
        chk("t6_lane1_en3", lane_log[2][15:8], 32'h80);
        chk("t6_lane3_en4", lane_log[3][31:24], 32'h7F);
        chk("t6_lane3_en5", lane_log[4][31:24], 32'h80);
        check_tile("t6", 0, 0, 2, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
